// File: rtl/flash_pkg.sv
// Shared encodings for the flash command controller: FSM states, SPI opcodes
// and the cmd_op selector codes, plus small lookup helpers.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ         = 2'd0;
    localparam logic [1:0] OP_READ_ID      = 2'd1;
    localparam logic [1:0] OP_READ_STATUS  = 2'd2;
    localparam logic [1:0] OP_WRITE_ENABLE = 2'd3;

    localparam logic [7:0] OPC_READ         = 8'h03;
    localparam logic [7:0] OPC_READ_ID      = 8'h9F;
    localparam logic [7:0] OPC_READ_STATUS  = 8'h05;
    localparam logic [7:0] OPC_WRITE_ENABLE = 8'h06;

    localparam logic [7:0] DUMMY_BYTE = 8'hFF;

    function automatic logic [7:0] opcode_of(input logic [1:0] op);
        logic [7:0] opc;
        case (op)
            OP_READ:        opc = OPC_READ;
            OP_READ_ID:     opc = OPC_READ_ID;
            OP_READ_STATUS: opc = OPC_READ_STATUS;
            default:        opc = OPC_WRITE_ENABLE;
        endcase
        return opc;
    endfunction

    // Number of data-phase bytes; len==0 encodes a full 256-byte read.
    function automatic logic [8:0] data_target(input logic [1:0] op, input logic [7:0] len);
        logic [8:0] tgt;
        case (op)
            OP_READ:        tgt = (len == 8'd0) ? 9'd256 : {1'b0, len};
            OP_READ_ID:     tgt = 9'd3;
            OP_READ_STATUS: tgt = 9'd1;
            default:        tgt = 9'd0;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/flash_cmd_ctrl.sv
// Flash command sequencer: drives opcode, address and dummy bytes to an SPI
// byte engine, returns received data bytes, and enforces a chip-select gap.
module flash_cmd_ctrl
    import flash_pkg::*;
#(
    parameter int GAP_CYCLES = 8
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        nCS_ctrl,
    output logic        wr_req,
    output logic [7:0]  data_in,
    input  logic        wr_ack,
    input  logic [7:0]  data_recv
);

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic [23:0]      addr_reg;
    logic [8:0]       target_reg;
    logic [8:0]       byte_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_READ;
            addr_reg     <= 24'd0;
            target_reg   <= 9'd0;
            byte_cnt_reg <= 9'd0;
            gap_cnt_reg  <= '0;
            cmd_busy     <= 1'b0;
            cmd_done     <= 1'b0;
            rd_data      <= 8'h00;
            rd_valid     <= 1'b0;
            nCS_ctrl     <= 1'b1;
            wr_req       <= 1'b0;
            data_in      <= 8'h00;
        end else begin
            rd_valid <= 1'b0;
            cmd_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_start) begin
                        op_reg       <= cmd_op;
                        addr_reg     <= addr;
                        target_reg   <= data_target(cmd_op, len);
                        byte_cnt_reg <= 9'd0;
                        nCS_ctrl     <= 1'b0;
                        wr_req       <= 1'b1;
                        data_in      <= opcode_of(cmd_op);
                        cmd_busy     <= 1'b1;
                        state_reg    <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (wr_ack) begin
                        byte_cnt_reg <= 9'd0;
                        case (op_reg)
                            OP_READ: begin
                                data_in   <= addr_reg[23:16];
                                state_reg <= ST_ADDR;
                            end
                            OP_WRITE_ENABLE: begin
                                nCS_ctrl    <= 1'b1;
                                wr_req      <= 1'b0;
                                data_in     <= 8'h00;
                                gap_cnt_reg <= '0;
                                state_reg   <= ST_GAP;
                            end
                            default: begin
                                wr_req    <= 1'b0;
                                data_in   <= DUMMY_BYTE;
                                state_reg <= ST_DATA;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (wr_ack) begin
                        if (byte_cnt_reg == 9'd2) begin
                            byte_cnt_reg <= 9'd0;
                            wr_req       <= 1'b0;
                            data_in      <= DUMMY_BYTE;
                            state_reg    <= ST_DATA;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 9'd1;
                            data_in      <= (byte_cnt_reg == 9'd0) ? addr_reg[15:8] : addr_reg[7:0];
                        end
                    end
                end
                ST_DATA: begin
                    if (wr_ack) begin
                        rd_data  <= data_recv;
                        rd_valid <= 1'b1;
                        // 9-bit compare so a 256-byte read terminates on count 255
                        if (byte_cnt_reg == target_reg - 9'd1) begin
                            byte_cnt_reg <= 9'd0;
                            nCS_ctrl     <= 1'b1;
                            data_in      <= 8'h00;
                            gap_cnt_reg  <= '0;
                            state_reg    <= ST_GAP;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 9'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg <= '0;
                        cmd_busy    <= 1'b0;
                        cmd_done    <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    nCS_ctrl  <= 1'b1;
                    wr_req    <= 1'b0;
                    cmd_busy  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
